block_copy_ctrl: RTL and testbench
==================================

Name: block_copy_ctrl

Overview:
Parametrised block-transfer controller that copies a run of words from a synchronous-read source memory (ROM/RAM) into a destination RAM. It is the successor to the fixed 16-word copy controller. It adds run-time base addresses and length, a configurable source read latency, a constant-fill mode, abort, and a busy/done handshake. It sits between a host sequencer and a source/destination memory pair in the data-path test designs.

Parameters:
ADDR_W, 4, width of source and destination addresses
DATA_W, 8, memory data width
LEN_W, 5, width of transfer length; must be ≥ ADDR_W+1 so a full 2^ADDR_W block is expressible
RD_LAT, 1, source read latency in cycles (rd_en at cycle n gives rd_data valid at n+RD_LAT); legal range 1..4

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start_sig  in  1  one-cycle request, sampled only in IDLE
abort  in  1  terminate the transfer in progress
mode  in  1  0 = copy, 1 = fill; latched at start
src_base  in  ADDR_W  first source address; latched at start
dst_base  in  ADDR_W  first destination address; latched at start
len  in  LEN_W  number of words; latched at start
fill_value  in  DATA_W  fill data; latched at start
rd_en  out  1  source read strobe
rd_addr  out  ADDR_W  source address
rd_data  in  DATA_W  source data, valid RD_LAT cycles after rd_en
write_en  out  1  destination write strobe
ram_addr  out  ADDR_W  destination address
wr_data  out  DATA_W  destination data
busy  out  1  high from the cycle after start is accepted until done_sig inclusive
done_sig  out  1  one-cycle completion pulse
aborted  out  1  valid with done_sig; 1 if the transfer ended by abort
words_done  out  LEN_W  count of writes issued in the current or last transfer

Behaviour:
- Reset (rst=1 at an edge): FSM=IDLE. All outputs 0 (rd_en, write_en, addresses, wr_data, busy, done_sig, aborted, words_done). Pipeline valid bits are cleared. Reset mid-transfer drops all in-flight writes.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start_sig=1 latches the parameters, clears words_done and aborted, sets busy and goes to RUN. With len=0 it goes straight to DONE: no reads, no writes, done_sig next cycle.
- start_sig outside IDLE is ignored. abort in IDLE is ignored. If start_sig and abort are both high in IDLE, start is accepted and abort has no effect that cycle.
- Copy mode, RUN: one read per cycle. rd_en=1 with rd_addr = src_base+k for k=0..len-1. The k-th read is issued in the k-th RUN cycle. Addresses wrap modulo 2^ADDR_W.
- Copy mode, write pipeline: a valid/offset shift register of depth RD_LAT. write_en=1 with ram_addr = dst_base+k and wr_data = rd_data exactly RD_LAT cycles after read k. Writes are continuous with no gaps.
- After the last read the FSM goes to DRAIN for RD_LAT cycles, then to DONE.
- Fill mode: rd_en stays 0. RUN emits write_en=1, ram_addr = dst_base+k, wr_data = fill_value for k=0..len-1, one per cycle. It then goes directly to DONE; DRAIN is skipped.
- Timing, start accepted at edge t:
  - copy: first rd_en at cycle t+1, first write_en at t+1+RD_LAT, last write_en at t+len+RD_LAT, done_sig at t+len+RD_LAT+1.
  - fill: first write at t+1, done_sig at t+len+1.
- DONE: done_sig=1 for exactly one cycle with busy still 1; IDLE follows. A new start is accepted in the first IDLE cycle.
- words_done increments on each write_en and holds its value after done.
- Abort in RUN or DRAIN, sampled at edge a:
  - from cycle a+1, rd_en=0 and write_en=0; in-flight reads are discarded;
  - done_sig=1 and aborted=1 at a+1;
  - words_done counts only the writes issued up to and including cycle a.
- Abort in the DONE cycle is ignored and aborted stays 0.
- Between transfers, rd_addr and ram_addr hold their last values; write_en and rd_en are 0.

Test Plan:
- Copy, RD_LAT=1, src_base=0, dst_base=0, len=16, source holds i+0x10 → 16 writes ram[i]=i+0x10, first write 2 cycles after start, done_sig at start+18, words_done=16, aborted=0.
- Copy with wrap, src_base=14, dst_base=3, len=4, RD_LAT=3 → rd_addr 14,15,0,1; writes to 3..6 beginning 4 cycles after start; done_sig at start+8.
- Fill, dst_base=8, len=5, fill_value=0xA5 → no rd_en; ram[8..12]=0xA5 on cycles start+1..start+5; done_sig at start+6.
- len=0 → no rd_en or write_en, done_sig one cycle after start, words_done=0.
- Copy len=10, RD_LAT=2, abort raised on the 4th RUN cycle → exactly 2 writes, done_sig and aborted=1 the following cycle, no further strobes. A start pulse during RUN is ignored. Back-to-back start in the first IDLE cycle is accepted.
- rst asserted mid-copy → next cycle all outputs 0 and FSM IDLE. No write_en from in-flight reads; a subsequent start runs a clean transfer.

Source files
------------

// File: rtl/block_copy_ctrl.sv
// Block-transfer controller: copies len words from a synchronous-read source into a
// destination RAM, or fills it with a constant, with abort and a busy/done handshake.
module block_copy_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_sig,
  input  logic              abort,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done_sig,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                    r_state;
  logic                          r_mode;
  logic [DATA_W-1:0]             r_fill;
  logic [LEN_W-1:0]              r_rem;
  logic [2:0]                    r_drn;
  logic                          r_iss;
  logic [ADDR_W-1:0]             r_src_a;
  logic [ADDR_W-1:0]             r_dst_a;
  logic [ADDR_W-1:0]             r_ram_hold;
  logic                          r_aborted;
  logic [LEN_W-1:0]              r_words;
  logic [RD_LAT-1:0]             r_vld_sr;
  logic [RD_LAT-1:0][ADDR_W-1:0] r_da_sr;

  logic                          w_start;
  logic                          w_kill;
  logic                          w_rd_iss;
  logic                          w_we;
  logic [ADDR_W-1:0]             w_wa;
  logic [RD_LAT:0]               w_vld_pipe;
  logic [RD_LAT:0][ADDR_W-1:0]   w_da_pipe;

  assign w_start  = (r_state == S_IDLE) && start_sig;
  assign w_kill   = abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_rd_iss = r_iss && !r_mode;

  // Stage 0 is the read being issued this cycle; stage RD_LAT lines up with rd_data.
  assign w_vld_pipe = {r_vld_sr, w_rd_iss};
  assign w_da_pipe  = {r_da_sr, r_dst_a};

  // Fill writes come straight from the issue stage; copy writes from the pipe tail.
  assign w_we = r_mode ? r_iss   : w_vld_pipe[RD_LAT];
  assign w_wa = r_mode ? r_dst_a : w_da_pipe[RD_LAT];

  assign rd_en      = w_rd_iss;
  assign rd_addr    = r_src_a;
  assign write_en   = w_we;
  assign ram_addr   = w_we ? w_wa : r_ram_hold;
  assign wr_data    = w_we ? (r_mode ? r_fill : rd_data) : '0;
  assign busy       = (r_state != S_IDLE);
  assign done_sig   = (r_state == S_DONE);
  assign aborted    = r_aborted;
  assign words_done = r_words;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_fill    <= '0;
      r_rem     <= '0;
      r_drn     <= '0;
      r_iss     <= 1'b0;
      r_src_a   <= '0;
      r_dst_a   <= '0;
      r_aborted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_sig) begin
            r_mode    <= mode;
            r_fill    <= fill_value;
            r_aborted <= 1'b0;
            r_dst_a   <= dst_base;
            if (len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
              r_iss   <= 1'b1;
              r_rem   <= len - LEN_W'(1);
              // rd_addr only moves when a copy will actually read
              if (!mode) r_src_a <= src_base;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state   <= S_DONE;
            r_iss     <= 1'b0;
            r_aborted <= 1'b1;
          end else if (r_rem == '0) begin
            r_iss <= 1'b0;
            if (r_mode) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_DRAIN;
              r_drn   <= 3'(RD_LAT - 1);
            end
          end else begin
            r_rem   <= r_rem - LEN_W'(1);
            r_dst_a <= r_dst_a + ADDR_W'(1);
            if (!r_mode) r_src_a <= r_src_a + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_state   <= S_DONE;
            r_aborted <= 1'b1;
          end else if (r_drn == '0) begin
            r_state <= S_DONE;
          end else begin
            r_drn <= r_drn - 3'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Abort and reset both discard whatever reads are still in flight.
  always_ff @(posedge clk) begin
    if (rst || w_kill) begin
      r_vld_sr <= '0;
      r_da_sr  <= '0;
    end else begin
      r_vld_sr <= w_vld_pipe[RD_LAT-1:0];
      r_da_sr  <= w_da_pipe[RD_LAT-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_words    <= '0;
      r_ram_hold <= '0;
    end else begin
      if (w_start)   r_words <= '0;
      else if (w_we) r_words <= r_words + LEN_W'(1);
      if (w_we) r_ram_hold <= w_wa;
    end
  end

endmodule

// File: tb/tb_block_copy_ctrl.sv
// Scoreboard bench for block_copy_ctrl: three instances (RD_LAT 1..3) share one stimulus
// stream; each has its own source-memory model, reference model and output monitor.
module tb_block_copy_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LW = 5;

  typedef struct { int cyc; int addr; int data; } ev_t;
  typedef struct { int cyc; int ab; int wd; } dn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_sig = 1'b0;
  logic          abort = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] fill_value = '0;
  logic [DW-1:0] src_mem [16];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  for (genvar gi = 1; gi <= 3; gi++) begin : g_lat
    localparam int L = gi;
    logic          rd_en, write_en, busy, done_sig, aborted;
    logic [AW-1:0] rd_addr, ram_addr;
    logic [DW-1:0] rd_data, wr_data;
    logic [LW-1:0] words_done;
    logic [DW-1:0] mp [1:L];
    ev_t  rq[$];
    ev_t  wq[$];
    ev_t  tmp[$];
    dn_t  dq[$];
    int   m_t = 0;
    int   m_done = -10;
    int   m_len = 0;
    logic m_mode = 1'b0;
    logic prev_rst = 1'b1;

    block_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(L)) dut (
      .clk(clk), .rst(rst), .start_sig(start_sig), .abort(abort), .mode(mode),
      .src_base(src_base), .dst_base(dst_base), .len(len), .fill_value(fill_value),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .write_en(write_en), .ram_addr(ram_addr), .wr_data(wr_data),
      .busy(busy), .done_sig(done_sig), .aborted(aborted), .words_done(words_done)
    );

    // Source memory with RD_LAT cycles of read latency.
    assign rd_data = mp[L];
    always @(posedge clk) begin
      mp[1] <= rd_en ? src_mem[rd_addr] : 8'h00;
      for (int i = 2; i <= L; i++) mp[i] <= mp[i-1];
    end

    function automatic int pending();
      return rq.size() + wq.size() + dq.size();
    endfunction

    // Reference model: expectations derived from start/abort cycles by arithmetic.
    always @(posedge clk) begin
      int  n, f, wd;
      ev_t e;
      dn_t d;
      n = cyc;
      if (rst) begin
        rq.delete(); wq.delete(); dq.delete();
        m_t = n; m_done = n;
      end else if (n > m_done) begin
        if (start_sig) begin
          m_t = n; m_len = int'(len); m_mode = mode;
          for (int k = 0; k < m_len; k++) begin
            if (!mode) begin
              e.cyc = n + 1 + k; e.addr = (int'(src_base) + k) % 16; e.data = 0;
              rq.push_back(e);
              e.cyc = n + 1 + L + k; e.data = int'(src_mem[e.addr]);
              e.addr = (int'(dst_base) + k) % 16;
              wq.push_back(e);
            end else begin
              e.cyc = n + 1 + k; e.addr = (int'(dst_base) + k) % 16; e.data = int'(fill_value);
              wq.push_back(e);
            end
          end
          if (m_len == 0) m_done = n + 1;
          else if (mode)  m_done = n + m_len + 1;
          else            m_done = n + m_len + L + 1;
          d.cyc = m_done; d.ab = 0; d.wd = m_len;
          dq.push_back(d);
        end
      end else if (abort && n > m_t && n < m_done) begin
        tmp.delete();
        foreach (rq[i]) if (rq[i].cyc <= n) tmp.push_back(rq[i]);
        rq = tmp;
        tmp.delete();
        foreach (wq[i]) if (wq[i].cyc <= n) tmp.push_back(wq[i]);
        wq = tmp;
        f  = m_mode ? m_t + 1 : m_t + 1 + L;
        wd = (n < f) ? 0 : ((n - f + 1 < m_len) ? n - f + 1 : m_len);
        void'(dq.pop_back());
        d.cyc = n + 1; d.ab = 1; d.wd = wd;
        dq.push_back(d);
        m_done = n + 1;
      end
    end

    // Monitor: every cycle compare strobes against the head of each queue.
    always @(negedge clk) begin
      int   c;
      logic er, ew, ed;
      c = cyc;
      if (prev_rst && !rst)
        chk($sformatf("L%0d post-reset outputs", L),
            int'({rd_en, write_en, busy, done_sig, aborted, rd_addr, ram_addr, wr_data, words_done}), 0);
      prev_rst = rst;
      if (!rst) begin
        er = (rq.size() > 0) && (rq[0].cyc == c);
        chk($sformatf("L%0d rd_en", L), int'(rd_en), int'(er));
        if (er) begin
          if (rd_en) chk($sformatf("L%0d rd_addr", L), int'(rd_addr), rq[0].addr);
          void'(rq.pop_front());
        end
        ew = (wq.size() > 0) && (wq[0].cyc == c);
        chk($sformatf("L%0d write_en", L), int'(write_en), int'(ew));
        if (ew) begin
          if (write_en) begin
            chk($sformatf("L%0d ram_addr", L), int'(ram_addr), wq[0].addr);
            chk($sformatf("L%0d wr_data", L), int'(wr_data), wq[0].data);
          end
          void'(wq.pop_front());
        end
        ed = (dq.size() > 0) && (dq[0].cyc == c);
        chk($sformatf("L%0d done_sig", L), int'(done_sig), int'(ed));
        if (ed) begin
          chk($sformatf("L%0d aborted", L), int'(aborted), dq[0].ab);
          chk($sformatf("L%0d words_done", L), int'(words_done), dq[0].wd);
          void'(dq.pop_front());
        end
        chk($sformatf("L%0d busy", L), int'(busy), int'(c > m_t && c <= m_done));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input logic m, input int s, input int d, input int l, input int fv);
    mode = m; src_base = AW'(s); dst_base = AW'(d); len = LW'(l); fill_value = DW'(fv);
    start_sig = 1'b1;
    tick();
    start_sig = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 200 && !(cyc > g_lat[1].m_done && cyc > g_lat[2].m_done && cyc > g_lat[3].m_done)) begin
      tick();
      k++;
    end
    chk("idle timeout", int'(k >= 200), 0);
  endtask

  task automatic rand_mem();
    foreach (src_mem[i]) src_mem[i] = DW'($urandom);
  endtask

  initial begin
    int l, d;
    foreach (src_mem[i]) src_mem[i] = DW'(i + 16);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    go(1'b0, 0, 0, 16, 0);          wait_idle();
    go(1'b0, 14, 3, 4, 0);          wait_idle();
    go(1'b1, 0, 8, 5, 8'hA5);       wait_idle();
    go(1'b0, 5, 5, 0, 0);           wait_idle();
    go(1'b1, 5, 5, 0, 8'h33);       wait_idle();
    // abort on 4th RUN cycle, ignored start during RUN, back-to-back start
    rand_mem();
    go(1'b0, 2, 9, 10, 0);
    tick(); start_sig = 1'b1; len = LW'(3);
    tick(); start_sig = 1'b0;
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    tick(); go(1'b0, 7, 1, 3, 0);   wait_idle();
    // start and abort together in IDLE
    abort = 1'b1; go(1'b1, 0, 2, 4, 8'h3C); abort = 1'b0; wait_idle();
    // abort in DRAIN, then abort in the DONE cycle of a fill
    go(1'b0, 3, 3, 2, 0); tick(); tick(); abort = 1'b1; tick(); abort = 1'b0; wait_idle();
    go(1'b1, 0, 6, 2, 8'h77); tick(); tick(); abort = 1'b1; tick(); abort = 1'b0; wait_idle();
    // start landing in DONE/DRAIN for some latencies and the first IDLE cycle for another
    go(1'b0, 0, 0, 4, 0); repeat (6) tick(); go(1'b1, 1, 1, 3, 8'h5A); wait_idle();
    // reset mid-copy, then a clean transfer
    rand_mem();
    go(1'b0, 0, 4, 12, 0); repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    go(1'b0, 9, 0, 6, 0);           wait_idle();
    repeat (40) begin
      rand_mem();
      l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      go(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         l, int'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        d = int'($urandom_range(0, l + 4));
        repeat (d) tick();
        abort = 1'b1;
        if ($urandom_range(0, 1) == 1) start_sig = 1'b1;
        tick();
        abort = 1'b0; start_sig = 1'b0;
      end
      wait_idle();
    end
    tick();
    chk("L1 pending", g_lat[1].pending(), 0);
    chk("L2 pending", g_lat[2].pending(), 0);
    chk("L3 pending", g_lat[3].pending(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
